mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the instruction-fetch stage (IF, requester 0) and the data-memory stage (DM, requester 1) of the 32-bit ARM pipeline.
- Arbitrates round-robin and sequences a fixed-latency memory access.
- Drives mem_sel, which controls the external 2:1 word multiplexer that selects the memory address between if_addr and dm_addr.
- Returns read data and a one-cycle done pulse to the granted requester.

---
 rtl/mem_port_arbiter_pkg.sv | 32 +++
 rtl/mem_port_arbiter_arb_rr_pick.sv | 30 +++
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared constants and types for the unified-memory port arbiter that sits
// between the instruction-fetch (IF) and data-memory (DM) pipeline stages.
//   WORD_WIDTH   : data/address width of the pipeline
//   MEM_LATENCY  : default number of memory cycles per access
//   CNT_WIDTH    : width of the access latency counter (covers 1..15)
//   SEL_IF/DM    : encoding of the external address mux select
//   arb_state_e  : arbiter FSM states
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

   localparam int WORD_WIDTH  = 32;
   localparam int MEM_LATENCY = 2;
   localparam int CNT_WIDTH   = 4;

   localparam logic SEL_IF = 1'b0;
   localparam logic SEL_DM = 1'b1;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_e;

   // Counter value loaded at grant: the last BUSY cycle is the one where the
   // counter reads zero, so LATENCY cycles need a start value of LATENCY-1.
   function automatic logic [CNT_WIDTH-1:0] latency_load(input int lat);
      return CNT_WIDTH'(lat - 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// arb_rr_pick
// Two-way round-robin pick (combinational).
//   req[1:0]   : request vector, bit 0 = IF, bit 1 = DM
//   last_grant : requester granted most recently (SEL_IF / SEL_DM)
//   grant      : requester to serve next (meaningful only when any_req is 1)
//   any_req    : at least one request is pending
// -----------------------------------------------------------------------------
module arb_rr_pick
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant,
   output logic       any_req
);

   // Single requester wins outright; on a tie the one not served last wins.
   always_comb begin
      grant   = SEL_IF;
      any_req = |req;
      case (req)
         2'b01:   grant = SEL_IF;
         2'b10:   grant = SEL_DM;
         2'b11:   grant = ~last_grant;
         default: grant = SEL_IF;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between IF (requester 0) and DM
// (requester 1). Round-robin grant, fixed-latency access, one-cycle done
// pulse with registered read data to the granted requester.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset
//   if_req    : IF read request, held until if_done
//   if_done   : one-cycle pulse, if_rdata valid in the same cycle
//   if_rdata  : IF read data register
//   dm_req    : DM request, held until dm_done
//   dm_we     : DM write enable, sampled at grant
//   dm_done   : one-cycle pulse, dm_rdata valid in the same cycle (reads)
//   dm_rdata  : DM read data register
//   mem_sel   : external address mux select (0 = IF, 1 = DM)
//   mem_en    : memory access enable
//   mem_we    : memory write strobe
//   mem_rdata : memory read data, valid in the last BUSY cycle
// The address mux and the write-data path (dm_wdata) live outside this block.
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int WORD_WIDTH = mem_port_arbiter_pkg::WORD_WIDTH,
   parameter int LATENCY    = MEM_LATENCY
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   output logic                  if_done,
   output logic [WORD_WIDTH-1:0] if_rdata,
   input  logic                  dm_req,
   input  logic                  dm_we,
   output logic                  dm_done,
   output logic [WORD_WIDTH-1:0] dm_rdata,
   output logic                  mem_sel,
   output logic                  mem_en,
   output logic                  mem_we,
   input  logic [WORD_WIDTH-1:0] mem_rdata
);

   arb_state_e            r_state;
   logic [CNT_WIDTH-1:0]  r_cnt;
   logic                  r_last_grant;
   logic                  r_mem_sel;
   logic                  r_mem_en;
   logic                  r_mem_we;
   logic                  r_if_done;
   logic                  r_dm_done;
   logic [WORD_WIDTH-1:0] r_if_rdata;
   logic [WORD_WIDTH-1:0] r_dm_rdata;

   logic [1:0]            w_req;
   logic                  w_grant;
   logic                  w_any_req;

   assign w_req = {dm_req, if_req};

   arb_rr_pick u_pick (
      .req        (w_req),
      .last_grant (r_last_grant),
      .grant      (w_grant),
      .any_req    (w_any_req)
   );

   // Arbiter FSM: grant in IDLE, count out the access in BUSY, pulse done in RESP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ARB_IDLE;
         r_cnt        <= 4'd0;
         r_last_grant <= SEL_DM;
         r_mem_sel    <= SEL_IF;
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_if_done    <= 1'b0;
         r_dm_done    <= 1'b0;
         r_if_rdata   <= '0;
         r_dm_rdata   <= '0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               r_if_done <= 1'b0;
               r_dm_done <= 1'b0;
               if (w_any_req) begin
                  r_state      <= ARB_BUSY;
                  r_mem_sel    <= w_grant;
                  r_last_grant <= w_grant;
                  r_mem_we     <= dm_we & (w_grant == SEL_DM);
                  r_mem_en     <= 1'b1;
                  r_cnt        <= latency_load(LATENCY);
               end else begin
                  r_state  <= ARB_IDLE;
                  r_mem_en <= 1'b0;
                  r_mem_we <= 1'b0;
               end
            end
            ARB_BUSY: begin
               if (r_cnt == 4'd0) begin
                  r_state  <= ARB_RESP;
                  r_mem_en <= 1'b0;
                  r_mem_we <= 1'b0;
                  if (r_mem_sel == SEL_IF) begin
                     r_if_done  <= 1'b1;
                     r_if_rdata <= mem_rdata;
                  end else begin
                     r_dm_done <= 1'b1;
                     // A write returns no data, so the last read value stays.
                     if (!r_mem_we) begin
                        r_dm_rdata <= mem_rdata;
                     end else begin
                        r_dm_rdata <= r_dm_rdata;
                     end
                  end
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            ARB_RESP: begin
               // Requests are not looked at here; a held request is
               // re-arbitrated from IDLE on the following edge.
               r_state   <= ARB_IDLE;
               r_if_done <= 1'b0;
               r_dm_done <= 1'b0;
            end
            default: begin
               r_state   <= ARB_IDLE;
               r_mem_en  <= 1'b0;
               r_mem_we  <= 1'b0;
               r_if_done <= 1'b0;
               r_dm_done <= 1'b0;
            end
         endcase
      end
   end

   assign if_done  = r_if_done;
   assign dm_done  = r_dm_done;
   assign if_rdata = r_if_rdata;
   assign dm_rdata = r_dm_rdata;
   assign mem_sel  = r_mem_sel;
   assign mem_en   = r_mem_en;
   assign mem_we   = r_mem_we;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter (LATENCY = 2). The driver pushes the
// expected access (requester, write flag, returned data) into a scoreboard
// queue; a monitor checks mem_sel/mem_we during every enabled cycle and pops
// and compares whenever a done pulse appears. A small memory model presents
// the access word only in the last enabled cycle.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, dm_req, dm_we;
   logic        if_done, dm_done, mem_sel, mem_en, mem_we;
   logic [31:0] if_rdata, dm_rdata, mem_rdata;

   typedef struct {
      logic        is_dm;
      logic        we;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          done_cyc[$];
   int          test_cnt  = 0;
   int          fail_cnt  = 0;
   int          done_seen = 0;
   int          cyc       = 0;
   int          en_run    = 0;
   int          acc_idx   = 0;
   logic        prev_done = 1'b0;
   logic [31:0] tab [0:15];

   mem_port_arbiter #(.WORD_WIDTH(32), .LATENCY(LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_done   (if_done),
      .if_rdata  (if_rdata),
      .dm_req    (dm_req),
      .dm_we     (dm_we),
      .dm_done   (dm_done),
      .dm_rdata  (dm_rdata),
      .mem_sel   (mem_sel),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      test_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic is_dm, input logic we, input logic [31:0] data);
      exp_t e;
      e.is_dm = is_dm;
      e.we    = we;
      e.data  = data;
      sb.push_back(e);
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for n further done pulses; returns just after the
   // falling edge of the last RESP cycle.
   task automatic wait_done(input int n);
      int target;
      target = done_seen + n;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         #1;
         if (done_seen >= target) break;
      end
      chk("done_count", done_seen, target);
   endtask

   // Memory model: word tab[acc_idx] only in the last enabled cycle, junk otherwise.
   always @(negedge clk) begin
      if (!rst) begin
         en_run = 0;
      end else if (mem_en) begin
         en_run = en_run + 1;
      end else begin
         if (en_run != 0) begin
            chk("mem_en_len", en_run, LAT);
            acc_idx = acc_idx + 1;
         end
         en_run = 0;
      end
      mem_rdata = (rst && mem_en && en_run == LAT) ? tab[acc_idx]
                                                   : (32'hBAD0_0000 + 32'(en_run));
   end

   // Monitor: checks live access attributes and done pulses against the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         if (mem_en) begin
            if (sb.size() == 0) begin
               chk("unexpected_mem_en", mem_en, 1'b0);
            end else begin
               chk("mem_sel", mem_sel, sb[0].is_dm);
               chk("mem_we", mem_we, sb[0].we);
            end
         end else if (mem_we) begin
            chk("mem_we_without_en", mem_we, 1'b0);
         end
         if (if_done && dm_done) chk("done_exclusive", 2'b11, 2'b01);
         if (if_done || dm_done) begin
            done_seen++;
            done_cyc.push_back(cyc);
            if (prev_done) chk("done_width", 2, 1);
            if (sb.size() == 0) begin
               chk("unexpected_done", {if_done, dm_done}, 2'b00);
            end else begin
               mon_e = sb.pop_front();
               chk("done_src_dm", dm_done, mon_e.is_dm);
               if (mon_e.is_dm) chk("dm_rdata", dm_rdata, mon_e.data);
               else             chk("if_rdata", if_rdata, mon_e.data);
            end
         end
         prev_done = if_done | dm_done;
      end else begin
         prev_done = 1'b0;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tab[0]  = 32'h1111_0000;  tab[1]  = 32'h2222_0001;
      tab[2]  = 32'h3333_0002;  tab[3]  = 32'h4444_0003;
      tab[4]  = 32'hE3A0_1005;  tab[5]  = 32'h5555_0005;
      tab[6]  = 32'h6666_0006;  tab[7]  = 32'h7777_0007;
      tab[8]  = 32'h8888_0008;  tab[9]  = 32'h9999_0009;
      tab[10] = 32'hAAAA_000A;  tab[11] = 32'hBBBB_000B;
      tab[12] = 32'hCCCC_000C;  tab[13] = 32'hDDDD_000D;
      tab[14] = 32'hEEEE_000E;  tab[15] = 32'hFFFF_000F;
      mem_rdata = 32'h0;

      // Reset with both requests high: everything quiet.
      rst = 1'b0; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
      repeat (3) edge1();
      @(negedge clk);
      chk("rst_if_done", if_done, 1'b0);
      chk("rst_dm_done", dm_done, 1'b0);
      chk("rst_mem_en", mem_en, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_sel", mem_sel, 1'b0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_dm_rdata", dm_rdata, 32'h0);

      // Both held: IF first, then strict alternation, dones 4 cycles apart.
      push(1'b0, 1'b0, tab[0]);
      push(1'b1, 1'b0, tab[1]);
      push(1'b0, 1'b0, tab[2]);
      push(1'b1, 1'b0, tab[3]);
      done_cyc.delete();
      edge1();
      rst = 1'b1;
      edge1();
      @(negedge clk);
      chk("first_grant_en", mem_en, 1'b1);
      chk("first_grant_sel", mem_sel, SEL_IF);
      wait_done(4);
      if_req = 1'b0; dm_req = 1'b0;
      chk("done_pulses", done_cyc.size(), 4);
      if (done_cyc.size() == 4) begin
         for (int i = 1; i < 4; i++) chk("done_gap", done_cyc[i] - done_cyc[i-1], LAT + 2);
      end

      // IF read alone returns the instruction word.
      edge1(); edge1();
      push(1'b0, 1'b0, tab[4]);
      if_req = 1'b1;
      wait_done(1);
      if_req = 1'b0;
      chk("if_word", if_rdata, 32'hE3A0_1005);

      // DM write: strobe high for both BUSY cycles, dm_rdata keeps tab[3].
      edge1();
      push(1'b1, 1'b1, tab[3]);
      dm_we = 1'b1; dm_req = 1'b1;
      wait_done(1);
      dm_req = 1'b0; dm_we = 1'b0;

      // Reset in the first BUSY cycle of a DM write.
      edge1(); edge1();
      dm_we = 1'b1; dm_req = 1'b1;
      edge1();
      rst = 1'b0;
      #1;
      chk("abort_mem_en", mem_en, 1'b0);
      chk("abort_mem_we", mem_we, 1'b0);
      @(negedge clk);
      chk("abort_dm_done", dm_done, 1'b0);
      chk("abort_dm_rdata", dm_rdata, 32'h0);
      dm_we = 1'b0; if_req = 1'b1;
      edge1(); edge1();
      push(1'b0, 1'b0, tab[6]);
      push(1'b1, 1'b0, tab[7]);
      rst = 1'b1;
      wait_done(1);
      if_req = 1'b0;
      wait_done(1);
      dm_req = 1'b0;

      // DM request dropped right after grant: access still completes.
      edge1();
      push(1'b1, 1'b0, tab[8]);
      dm_req = 1'b1;
      edge1();
      dm_req = 1'b0;
      wait_done(1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("idle_no_grant", mem_en, 1'b0);
      end

      chk("scoreboard_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule
